// File: rtl/rv32_axil_lsu.sv
// rv32_axil_lsu: load/store unit bridging MEM-stage requests onto an AXI-Lite
// master for IO space. One transaction outstanding at a time.
//
// Ports:
//   aclk, areset_n (sync, active-low), flush (discard in-flight response)
//   req_*   : request channel (we, byte addr, size, unsigned, right-aligned wdata)
//   rsp_*   : response channel (extended rdata, err 00 ok/01 misalign/10 bus/11 timeout)
//   m_axil_*: AXI-Lite master (AW, W, B, AR, R)
//   dbg_state: current FSM state encoding
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising edge where valid & ready are both high; a valid, once raised, stays
// high with stable payload until that transfer.
module rv32_axil_lsu #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    flush,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_err,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready,
    output logic [2:0]              dbg_state
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0, WADDR = 3'd1, WRESP = 3'd2, RADDR = 3'd3,
        RDATA = 3'd4, RSP = 3'd5, DRAIN = 3'd6
    } state_t;

    state_t state, state_n, drain_st, drain_st_n, eff_st, bus_next;
    logic aw_done, aw_done_n, w_done, w_done_n;
    logic tx_pend, tx_pend_n, flushed, flushed_n;
    logic [31:0] tmo_cnt, tmo_cnt_n;
    logic we_q, uns_q;
    logic [1:0] size_q;
    logic [OFF_W-1:0] off_q;
    logic accept, misalign, bus_done, rsp_load;
    logic [1:0] bus_resp, rsp_err_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_n, st_data, ld_shift, ld_mask, ld_ext;
    logic [STRB_W-1:0] st_strb;
    logic ld_sign;
    logic [ADDR_WIDTH-1:0] bus_addr;

    // After a timeout the AXI transaction is still live; drain_st tracks its
    // phase so the channel signals keep their obligations during RSP/DRAIN.
    assign eff_st = (state == DRAIN || (state == RSP && tx_pend)) ? drain_st : state;

    assign req_ready      = areset_n && (state == IDLE) && !flush;
    assign rsp_valid      = (state == RSP);
    assign m_axil_awvalid = (eff_st == WADDR) && !aw_done;
    assign m_axil_wvalid  = (eff_st == WADDR) && !w_done;
    assign m_axil_bready  = (eff_st == WRESP);
    assign m_axil_arvalid = (eff_st == RADDR);
    assign m_axil_rready  = (eff_st == RDATA);
    assign m_axil_awprot  = 3'b000;
    assign m_axil_arprot  = 3'b000;
    assign dbg_state      = state;
    assign accept         = req_valid && req_ready;
    assign bus_addr       = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    // Request decode: alignment, replicated store data, byte strobes.
    always_comb begin
        misalign = 1'b0;
        st_data  = req_wdata;
        st_strb  = STRB_W'(8'hFF);
        case (req_size)
            2'd0: begin
                st_data = {STRB_W{req_wdata[7:0]}};
                st_strb = STRB_W'(8'h01);
            end
            2'd1: begin
                misalign = req_addr[0];
                st_data  = {(STRB_W/2){req_wdata[15:0]}};
                st_strb  = STRB_W'(8'h03);
            end
            2'd2: begin
                misalign = |req_addr[1:0];
                st_data  = {(STRB_W/4){req_wdata[31:0]}};
                st_strb  = STRB_W'(8'h0F);
            end
            default: misalign = (DATA_WIDTH == 32) || (|req_addr[2:0]);
        endcase
    end

    // Load data: lane-steer, truncate to size, then sign or zero extend.
    always_comb begin
        ld_shift = m_axil_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    begin ld_mask = DATA_WIDTH'(8'hFF);         ld_sign = ld_shift[7];  end
            2'd1:    begin ld_mask = DATA_WIDTH'(16'hFFFF);      ld_sign = ld_shift[15]; end
            2'd2:    begin ld_mask = DATA_WIDTH'(32'hFFFF_FFFF); ld_sign = ld_shift[31]; end
            default: begin ld_mask = '1;                         ld_sign = 1'b0;         end
        endcase
        ld_ext = (ld_shift & ld_mask) | ({DATA_WIDTH{ld_sign && !uns_q}} & ~ld_mask);
    end

    always_comb begin
        // Bus-phase progression, shared by live and draining transactions.
        bus_next  = eff_st;
        bus_done  = 1'b0;
        bus_resp  = 2'b00;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (eff_st)
            WADDR: begin
                aw_done_n = aw_done || m_axil_awready;
                w_done_n  = w_done || m_axil_wready;
                if (aw_done_n && w_done_n) bus_next = WRESP;
            end
            WRESP: if (m_axil_bvalid) begin bus_done = 1'b1; bus_resp = m_axil_bresp; end
            RADDR: if (m_axil_arready) bus_next = RDATA;
            RDATA: if (m_axil_rvalid) begin bus_done = 1'b1; bus_resp = m_axil_rresp; end
            default: ;
        endcase

        state_n     = state;
        drain_st_n  = drain_st;
        tx_pend_n   = tx_pend;
        flushed_n   = flushed;
        tmo_cnt_n   = tmo_cnt;
        rsp_load    = 1'b0;
        rsp_err_n   = 2'b00;
        rsp_rdata_n = '0;
        case (state)
            IDLE: if (accept) begin
                tmo_cnt_n = '0;
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
                flushed_n = 1'b0;
                tx_pend_n = 1'b0;
                if (misalign) begin
                    state_n   = RSP;
                    rsp_load  = 1'b1;
                    rsp_err_n = 2'b01;
                end else begin
                    state_n = req_we ? WADDR : RADDR;
                end
            end
            WADDR, WRESP, RADDR, RDATA: begin
                tmo_cnt_n = tmo_cnt + 32'd1;
                if (flush) flushed_n = 1'b1;
                if (bus_done) begin
                    // A bus response beats a coincident timeout.
                    if (flushed || flush) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = RSP;
                        rsp_load  = 1'b1;
                        rsp_err_n = (bus_resp inside {2'b10, 2'b11}) ? 2'b10 : 2'b00;
                        rsp_rdata_n = (we_q || rsp_err_n != 2'b00) ? '0 : ld_ext;
                    end
                end else if (TIMEOUT_CYCLES != 0 && tmo_cnt_n == TIMEOUT_CYCLES) begin
                    tx_pend_n  = 1'b1;
                    drain_st_n = bus_next;
                    if (flushed || flush) begin
                        state_n = DRAIN;
                    end else begin
                        state_n   = RSP;
                        rsp_load  = 1'b1;
                        rsp_err_n = 2'b11;
                    end
                end else begin
                    state_n = bus_next;
                end
            end
            RSP: begin
                if (tx_pend) begin
                    drain_st_n = bus_next;
                    if (bus_done) tx_pend_n = 1'b0;
                end
                if (flush || rsp_ready) state_n = tx_pend_n ? DRAIN : IDLE;
            end
            DRAIN: begin
                drain_st_n = bus_next;
                if (bus_done) begin
                    tx_pend_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state         <= IDLE;
            drain_st      <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            tx_pend       <= 1'b0;
            flushed       <= 1'b0;
            tmo_cnt       <= '0;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            size_q        <= 2'd0;
            off_q         <= '0;
            m_axil_awaddr <= '0;
            m_axil_araddr <= '0;
            m_axil_wdata  <= '0;
            m_axil_wstrb  <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 2'b00;
        end else begin
            state    <= state_n;
            drain_st <= drain_st_n;
            aw_done  <= aw_done_n;
            w_done   <= w_done_n;
            tx_pend  <= tx_pend_n;
            flushed  <= flushed_n;
            tmo_cnt  <= tmo_cnt_n;
            if (accept && !misalign) begin
                we_q   <= req_we;
                uns_q  <= req_unsigned;
                size_q <= req_size;
                off_q  <= req_addr[OFF_W-1:0];
                if (req_we) begin
                    m_axil_awaddr <= bus_addr;
                    m_axil_wdata  <= st_data;
                    m_axil_wstrb  <= st_strb << req_addr[OFF_W-1:0];
                end else begin
                    m_axil_araddr <= bus_addr;
                end
            end
            if (rsp_load) begin
                rsp_rdata <= rsp_rdata_n;
                rsp_err   <= rsp_err_n;
            end
        end
    end
endmodule
